// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared constants and the buffered write-entry type for regfile_writeback
package regfile_wb_pkg;
    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;
    localparam int REG_ZERO = 0;
    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: LSU/ALU result handshakes, retire controls and register-file write port
interface regfile_writeback_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_addr;
    logic [DW-1:0]   lsu_data;
    logic            alu_valid;
    logic            alu_ready;
    logic [AW-1:0]   alu_addr;
    logic [DW-1:0]   alu_data;
    logic            wb_stall;
    logic            flush;
    logic [AW-1:0]   write_addr;
    logic            write_enable;
    logic [DW-1:0]   data_in;
    logic [2**AW-1:0] pending;
    logic [31:0]     wr_count;
    modport slave (
        input  lsu_valid, lsu_addr, lsu_data, alu_valid, alu_addr, alu_data, wb_stall, flush,
        output lsu_ready, alu_ready, write_addr, write_enable, data_in, pending, wr_count
    );
    modport master (
        output lsu_valid, lsu_addr, lsu_data, alu_valid, alu_addr, alu_data, wb_stall, flush,
        input  lsu_ready, alu_ready, write_addr, write_enable, data_in, pending, wr_count
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: generic DEPTH-entry synchronous FIFO with flush and a per-entry valid/contents view
module wb_fifo #(
    parameter int  DEPTH = 4,
    parameter type T = logic [7:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  T                 i_data,
    output T                 o_head,
    output logic             o_full,
    output logic             o_empty,
    output T                 o_entries [DEPTH],
    output logic [DEPTH-1:0] o_valid
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] r_rd, r_wr;
    logic [PW:0]   r_cnt;
    T              r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + 1'b1;
            end
            if (i_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(i_pop);
        end
    end
    assign o_full    = r_cnt == (PW+1)'(DEPTH);
    assign o_empty   = r_cnt == '0;
    assign o_head    = o_empty ? '0 : r_mem[r_rd];
    assign o_entries = r_mem;
    // an entry is live when its distance from the read pointer is below the count
    always_comb begin
        o_valid = '0;
        for (int i = 0; i < DEPTH; i++) o_valid[i] = {1'b0, PW'(PW'(i) - r_rd)} < r_cnt;
    end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: LSU/ALU result arbiter and buffered register-file write sequencer with RAW scoreboard
// Optional same-cycle bypass when the FIFO is empty: define REGFILE_WB_BYPASS_EN.
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input logic clk,
    input logic rst,
    regfile_writeback_if.slave bus
);
    wb_entry_t        w_in, w_head;
    wb_entry_t        w_entries [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic [AW-1:0]    w_addr;
    logic [DW-1:0]    w_data;
    logic             w_full, w_empty, w_lsu_fire, w_fire, w_push, w_pop, w_byp;
    logic [2**AW-1:0] w_pending;
    logic [31:0]      r_wr_count;
    assign bus.lsu_ready = !w_full;
    assign bus.alu_ready = !w_full && !bus.lsu_valid;
    assign w_lsu_fire    = bus.lsu_valid && bus.lsu_ready;
    assign w_fire        = w_lsu_fire || (bus.alu_valid && bus.alu_ready);
    assign w_addr        = w_lsu_fire ? bus.lsu_addr : bus.alu_addr;
    assign w_data        = w_lsu_fire ? bus.lsu_data : bus.alu_data;
    assign w_in          = '{addr: w_addr, data: w_data};
`ifdef REGFILE_WB_BYPASS_EN
    assign w_byp = w_fire && w_addr != AW'(REG_ZERO) && w_empty && !bus.wb_stall && !bus.flush && !rst;
`else
    assign w_byp = 1'b0;
`endif
    // x0 results complete the handshake but are dropped here
    assign w_push = w_fire && w_addr != AW'(REG_ZERO) && !w_byp;
    assign w_pop  = !w_empty && !bus.wb_stall && !bus.flush && !rst;
    wb_fifo #(.DEPTH(DEPTH), .T(wb_entry_t)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_flush  (bus.flush),
        .i_data   (w_in),
        .o_head   (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_entries(w_entries),
        .o_valid  (w_valid)
    );
    assign bus.write_enable = w_pop || w_byp;
    assign bus.write_addr   = w_byp ? w_in.addr : w_head.addr;
    assign bus.data_in      = w_byp ? w_in.data : w_head.data;
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) if (w_valid[i]) w_pending[w_entries[i].addr] = 1'b1;
    end
    assign bus.pending = w_pending;
    always_ff @(posedge clk) begin
        if (rst) r_wr_count <= '0;
        else     r_wr_count <= r_wr_count + 32'(bus.write_enable);
    end
    assign bus.wr_count = r_wr_count;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed checks of arbitration, ordering, full, x0, flush and reset
module tb_regfile_writeback;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    regfile_writeback_if #(.AW(5), .DW(32)) bus ();
    regfile_writeback #(.DEPTH(4), .AW(5), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.lsu_valid = 0; bus.lsu_addr = 0; bus.lsu_data = 0;
        bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
        bus.wb_stall = 0; bus.flush = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
        checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b exp 0", bus.write_enable); end
        checks++; if (bus.write_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d exp 0", bus.write_addr); end
        checks++; if (bus.data_in !== 32'd0) begin errors++; $display("FAIL reset_data: got %0h exp 0", bus.data_in); end
        checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL reset_pending: got %0h exp 0", bus.pending); end
        checks++; if (bus.wr_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", bus.wr_count); end
        checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_lsu_ready: got %0b exp 1", bus.lsu_ready); end
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %0b exp 1", bus.alu_ready); end
    endtask

    task automatic test_alu_single();
        bus.alu_valid = 1; bus.alu_addr = 5; bus.alu_data = 32'hDEADBEEF;
        #1;
        checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL single_we_early: got %0b exp 0", bus.write_enable); end
        tick();
        bus.alu_valid = 0;
        #1;
        checks++; if (bus.write_enable !== 1'b1) begin errors++; $display("FAIL single_we: got %0b exp 1", bus.write_enable); end
        checks++; if (bus.write_addr !== 5'd5) begin errors++; $display("FAIL single_addr: got %0d exp 5", bus.write_addr); end
        checks++; if (bus.data_in !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %0h exp deadbeef", bus.data_in); end
        checks++; if (bus.pending !== 32'h20) begin errors++; $display("FAIL single_pending: got %0h exp 20", bus.pending); end
        tick();
        checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL single_we_after: got %0b exp 0", bus.write_enable); end
        checks++; if (bus.wr_count !== 32'd1) begin errors++; $display("FAIL single_count: got %0d exp 1", bus.wr_count); end
    endtask

    task automatic test_priority();
        bus.lsu_valid = 1; bus.lsu_addr = 3; bus.lsu_data = 32'h33;
        bus.alu_valid = 1; bus.alu_addr = 4; bus.alu_data = 32'h44;
        #1;
        checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL prio_lsu_ready: got %0b exp 1", bus.lsu_ready); end
        checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL prio_alu_ready: got %0b exp 0", bus.alu_ready); end
        tick();
        bus.lsu_valid = 0;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL prio_alu_ready2: got %0b exp 1", bus.alu_ready); end
        checks++; if (bus.write_addr !== 5'd3 || bus.data_in !== 32'h33) begin errors++; $display("FAIL prio_first: got %0d/%0h exp 3/33", bus.write_addr, bus.data_in); end
        tick();
        bus.alu_valid = 0;
        #1;
        checks++; if (bus.write_enable !== 1'b1 || bus.write_addr !== 5'd4 || bus.data_in !== 32'h44) begin errors++; $display("FAIL prio_second: got %0b/%0d/%0h exp 1/4/44", bus.write_enable, bus.write_addr, bus.data_in); end
        tick();
        checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL prio_we_after: got %0b exp 0", bus.write_enable); end
        checks++; if (bus.wr_count !== 32'd3) begin errors++; $display("FAIL prio_count: got %0d exp 3", bus.wr_count); end
    endtask

    task automatic test_full_stall();
        logic [4:0] addrs [4] = '{5'd7, 5'd8, 5'd9, 5'd10};
        bus.wb_stall = 1;
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1; bus.alu_addr = addrs[i]; bus.alu_data = 32'h70 + 32'(i);
            tick();
        end
        bus.alu_valid = 0;
        bus.lsu_valid = 1; bus.lsu_addr = 20; bus.lsu_data = 32'hBAD;
        #1;
        checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL full_lsu_ready: got %0b exp 0", bus.lsu_ready); end
        checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL full_alu_ready: got %0b exp 0", bus.alu_ready); end
        checks++; if (bus.pending !== 32'h0000_0780) begin errors++; $display("FAIL full_pending: got %0h exp 780", bus.pending); end
        checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL full_we_stalled: got %0b exp 0", bus.write_enable); end
        tick();
        bus.wb_stall = 0;
        #1;
        checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL full_no_pushthrough: got %0b exp 0", bus.lsu_ready); end
        bus.lsu_valid = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.write_enable !== 1'b1 || bus.write_addr !== addrs[i] || bus.data_in !== 32'h70 + 32'(i)) begin errors++; $display("FAIL full_drain%0d: got %0b/%0d/%0h exp 1/%0d/%0h", i, bus.write_enable, bus.write_addr, bus.data_in, addrs[i], 32'h70 + 32'(i)); end
            tick();
        end
        checks++; if (bus.write_enable !== 1'b0 || bus.pending !== 32'd0) begin errors++; $display("FAIL full_drained: got we=%0b pend=%0h exp 0/0", bus.write_enable, bus.pending); end
        checks++; if (bus.wr_count !== 32'd7) begin errors++; $display("FAIL full_count: got %0d exp 7", bus.wr_count); end
    endtask

    task automatic test_x0();
        bus.alu_valid = 1; bus.alu_addr = 0; bus.alu_data = 32'h1234;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %0b exp 1", bus.alu_ready); end
        tick();
        bus.alu_valid = 0;
        #1;
        checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL x0_we: got %0b exp 0", bus.write_enable); end
        checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL x0_pending: got %0h exp 0", bus.pending); end
        tick();
        checks++; if (bus.wr_count !== 32'd7) begin errors++; $display("FAIL x0_count: got %0d exp 7", bus.wr_count); end
    endtask

    task automatic test_flush();
        bus.wb_stall = 1;
        for (int i = 1; i <= 3; i++) begin
            bus.alu_valid = 1; bus.alu_addr = 5'(i); bus.alu_data = 32'(i);
            tick();
        end
        bus.alu_valid = 0;
        #1;
        checks++; if (bus.pending !== 32'h0000_000E) begin errors++; $display("FAIL flush_pending_before: got %0h exp e", bus.pending); end
        bus.wb_stall = 0; bus.flush = 1;
        bus.alu_valid = 1; bus.alu_addr = 6; bus.alu_data = 32'h66;
        #1;
        checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL flush_we: got %0b exp 0", bus.write_enable); end
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL flush_alu_ready: got %0b exp 1", bus.alu_ready); end
        tick();
        bus.flush = 0; bus.alu_valid = 0;
        #1;
        checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL flush_we_after: got %0b exp 0", bus.write_enable); end
        checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL flush_pending: got %0h exp 0", bus.pending); end
        tick();
        checks++; if (bus.wr_count !== 32'd7) begin errors++; $display("FAIL flush_count: got %0d exp 7", bus.wr_count); end
    endtask

    task automatic test_reset_mid();
        bus.wb_stall = 1;
        for (int i = 11; i <= 13; i++) begin
            bus.alu_valid = 1; bus.alu_addr = 5'(i); bus.alu_data = 32'(i);
            tick();
        end
        bus.alu_valid = 0; bus.wb_stall = 0; rst = 1;
        #1;
        checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %0b exp 0", bus.write_enable); end
        tick();
        rst = 0;
        #1;
        checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL rstmid_we_after: got %0b exp 0", bus.write_enable); end
        checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL rstmid_pending: got %0h exp 0", bus.pending); end
        checks++; if (bus.wr_count !== 32'd0) begin errors++; $display("FAIL rstmid_count: got %0d exp 0", bus.wr_count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            bus.alu_valid = 1; bus.alu_addr = 5; bus.alu_data = 32'(i);
            tick();
            #1;
            checks++; if (bus.write_enable !== 1'b1 || bus.write_addr !== 5'd5 || bus.data_in !== 32'(i)) begin errors++; $display("FAIL b2b_%0d: got %0b/%0d/%0h exp 1/5/%0h", i, bus.write_enable, bus.write_addr, bus.data_in, i); end
        end
        bus.alu_valid = 0;
        tick();
        checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL b2b_we_after: got %0b exp 0", bus.write_enable); end
        checks++; if (bus.wr_count !== 32'd3) begin errors++; $display("FAIL b2b_count: got %0d exp 3", bus.wr_count); end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_priority();
        test_full_stall();
        test_x0();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
